// File: rtl/axil_regbank_n.sv
// AXI4-Lite slave with NUM_REGS byte-writable registers, flat readout and per-register write strobes.
// Optional macro AXIL_REGBANK_SLVERR_EN: out-of-range accesses answer SLVERR instead of OKAY.
module axil_regbank_n #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int NUM_REGS           = 16,
    parameter int C_S_AXI_ADDR_WIDTH = 8
) (
    input  logic                                   ACLK,
    input  logic                                   ARESET,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]          AWADDR,
    input  logic [2:0]                             AWPROT,
    input  logic                                   AWVALID,
    output logic                                   AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]          WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]        WSTRB,
    input  logic                                   WVALID,
    output logic                                   WREADY,
    output logic [1:0]                             BRESP,
    output logic                                   BVALID,
    input  logic                                   BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]          ARADDR,
    input  logic [2:0]                             ARPROT,
    input  logic                                   ARVALID,
    output logic                                   ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]          RDATA,
    output logic [1:0]                             RRESP,
    output logic                                   RVALID,
    input  logic                                   RREADY,
    output logic [NUM_REGS*C_S_AXI_DATA_WIDTH-1:0] regs_out,
    output logic [NUM_REGS-1:0]                    wr_pulse
);

    localparam int W        = C_S_AXI_DATA_WIDTH;
    localparam int NB       = W / 8;
    localparam int AW       = C_S_AXI_ADDR_WIDTH;
    localparam int ADDR_LSB = $clog2(NB);
    localparam int IDX_W    = $clog2(NUM_REGS);
    localparam int IDX_HI   = ADDR_LSB + IDX_W;

    localparam logic [1:0] RESP_OKAY = 2'b00;
`ifdef AXIL_REGBANK_SLVERR_EN
    localparam logic [1:0] RESP_OOR = 2'b10;
`else
    localparam logic [1:0] RESP_OOR = 2'b00;
`endif

    typedef enum logic [1:0] {
        W_IDLE      = 2'd0,
        W_ADDR_HELD = 2'd1,
        W_DATA_HELD = 2'd2,
        W_RESP      = 2'd3
    } wstate_t;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_RESP = 1'b1
    } rstate_t;

    function automatic logic [W-1:0] byte_merge(input logic [W-1:0] old_v,
                                                input logic [W-1:0] new_v,
                                                input logic [NB-1:0] strb);
        logic [W-1:0] res;
        for (int b = 0; b < NB; b++) begin
            if (strb[b]) begin
                res[b*8 +: 8] = new_v[b*8 +: 8];
            end else begin
                res[b*8 +: 8] = old_v[b*8 +: 8];
            end
        end
        return res;
    endfunction

    // Any set bit above the index field makes the address out of range.
    function automatic logic addr_in_range(input logic [AW-1:0] a);
        return (a[AW-1:IDX_HI] == {(AW-IDX_HI){1'b0}});
    endfunction

    wstate_t              wstate_r;
    rstate_t              rstate_r;
    logic [AW-1:0]        awaddr_held_r;
    logic [W-1:0]         wdata_held_r;
    logic [NB-1:0]        wstrb_held_r;
    logic                 awready_r;
    logic                 wready_r;
    logic                 bvalid_r;
    logic [1:0]           bresp_r;
    logic [NUM_REGS-1:0]  wr_pulse_r;
    logic                 arready_r;
    logic                 rvalid_r;
    logic [W-1:0]         rdata_r;
    logic [1:0]           rresp_r;
    logic [W-1:0]         regs_r [NUM_REGS];

    logic                 aw_hs_s;
    logic                 w_hs_s;
    logic                 commit_s;
    logic [AW-1:0]        c_addr_s;
    logic [W-1:0]         c_data_s;
    logic [NB-1:0]        c_strb_s;
    logic                 c_inr_s;
    logic [IDX_W-1:0]     c_idx_s;
    logic                 unused_s;

    // Pick the address/data pair to commit: held half from a register, the other live from the bus.
    always_comb begin
        aw_hs_s  = AWVALID && awready_r;
        w_hs_s   = WVALID && wready_r;
        c_addr_s = AWADDR;
        c_data_s = WDATA;
        c_strb_s = WSTRB;
        commit_s = 1'b0;
        case (wstate_r)
            W_IDLE: begin
                commit_s = aw_hs_s && w_hs_s;
            end
            W_ADDR_HELD: begin
                commit_s = w_hs_s;
                c_addr_s = awaddr_held_r;
            end
            W_DATA_HELD: begin
                commit_s = aw_hs_s;
                c_data_s = wdata_held_r;
                c_strb_s = wstrb_held_r;
            end
            default: begin
                commit_s = 1'b0;
            end
        endcase
        c_inr_s = addr_in_range(c_addr_s);
        c_idx_s = c_addr_s[ADDR_LSB +: IDX_W];
    end

    // Write channel FSM with registered ready/response/strobe outputs.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            wstate_r      <= W_IDLE;
            awaddr_held_r <= {AW{1'b0}};
            wdata_held_r  <= {W{1'b0}};
            wstrb_held_r  <= {NB{1'b0}};
            awready_r     <= 1'b0;
            wready_r      <= 1'b0;
            bvalid_r      <= 1'b0;
            bresp_r       <= 2'b00;
            wr_pulse_r    <= {NUM_REGS{1'b0}};
        end else begin
            wr_pulse_r <= {NUM_REGS{1'b0}};
            if (commit_s) begin
                wstate_r  <= W_RESP;
                awready_r <= 1'b0;
                wready_r  <= 1'b0;
                bvalid_r  <= 1'b1;
                bresp_r   <= c_inr_s ? RESP_OKAY : RESP_OOR;
                if (c_inr_s) begin
                    wr_pulse_r[c_idx_s] <= 1'b1;
                end
            end else begin
                case (wstate_r)
                    W_IDLE: begin
                        if (aw_hs_s) begin
                            awaddr_held_r <= AWADDR;
                            wstate_r      <= W_ADDR_HELD;
                            awready_r     <= 1'b0;
                            wready_r      <= 1'b1;
                        end else if (w_hs_s) begin
                            wdata_held_r <= WDATA;
                            wstrb_held_r <= WSTRB;
                            wstate_r     <= W_DATA_HELD;
                            awready_r    <= 1'b1;
                            wready_r     <= 1'b0;
                        end else begin
                            awready_r <= 1'b1;
                            wready_r  <= 1'b1;
                        end
                    end
                    W_ADDR_HELD: begin
                        awready_r <= 1'b0;
                        wready_r  <= 1'b1;
                    end
                    W_DATA_HELD: begin
                        awready_r <= 1'b1;
                        wready_r  <= 1'b0;
                    end
                    W_RESP: begin
                        if (BREADY) begin
                            bvalid_r  <= 1'b0;
                            wstate_r  <= W_IDLE;
                            awready_r <= 1'b1;
                            wready_r  <= 1'b1;
                        end else begin
                            awready_r <= 1'b0;
                            wready_r  <= 1'b0;
                        end
                    end
                    default: begin
                        wstate_r  <= W_IDLE;
                        awready_r <= 1'b0;
                        wready_r  <= 1'b0;
                        bvalid_r  <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Register storage: byte-lane merge on an in-range commit.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            for (int k = 0; k < NUM_REGS; k++) begin
                regs_r[k] <= {W{1'b0}};
            end
        end else if (commit_s && c_inr_s) begin
            regs_r[c_idx_s] <= byte_merge(regs_r[c_idx_s], c_data_s, c_strb_s);
        end
    end

    // Read channel FSM; data captured on the AR handshake edge, so a same-edge write is not seen.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            rstate_r  <= R_IDLE;
            arready_r <= 1'b0;
            rvalid_r  <= 1'b0;
            rdata_r   <= {W{1'b0}};
            rresp_r   <= 2'b00;
        end else begin
            case (rstate_r)
                R_IDLE: begin
                    if (ARVALID && arready_r) begin
                        rstate_r  <= R_RESP;
                        arready_r <= 1'b0;
                        rvalid_r  <= 1'b1;
                        if (addr_in_range(ARADDR)) begin
                            rdata_r <= regs_r[ARADDR[ADDR_LSB +: IDX_W]];
                            rresp_r <= RESP_OKAY;
                        end else begin
                            rdata_r <= {W{1'b0}};
                            rresp_r <= RESP_OOR;
                        end
                    end else begin
                        arready_r <= 1'b1;
                    end
                end
                R_RESP: begin
                    if (RREADY) begin
                        rstate_r  <= R_IDLE;
                        rvalid_r  <= 1'b0;
                        arready_r <= 1'b1;
                    end else begin
                        arready_r <= 1'b0;
                    end
                end
                default: begin
                    rstate_r  <= R_IDLE;
                    arready_r <= 1'b0;
                    rvalid_r  <= 1'b0;
                end
            endcase
        end
    end

    for (genvar k = 0; k < NUM_REGS; k++) begin : g_flat
        assign regs_out[k*W +: W] = regs_r[k];
    end

    assign AWREADY  = awready_r;
    assign WREADY   = wready_r;
    assign BVALID   = bvalid_r;
    assign BRESP    = bresp_r;
    assign wr_pulse = wr_pulse_r;
    assign ARREADY  = arready_r;
    assign RVALID   = rvalid_r;
    assign RDATA    = rdata_r;
    assign RRESP    = rresp_r;

    // Protection bits and sub-word address bits carry no meaning for this bank.
    assign unused_s = ^{AWPROT, ARPROT, c_addr_s[ADDR_LSB-1:0], ARADDR[ADDR_LSB-1:0]};

endmodule
